// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline slice: register-number width,
// ALU op class constants and the registered EX control bundle.
package id_ex_stage_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_IMM    = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_w;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
    } ex_ctrl_t;

    // A bubble is an address-add that neither writes the register file nor touches memory.
    localparam ex_ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load in EX whose target is read by the
// instruction in ID forces one bubble. $0 never creates a hazard.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic     ex_mem_rd_i,
    input  reg_idx_t ex_rt_i,
    input  reg_idx_t id_rs_i,
    input  reg_idx_t id_rt_i,
    input  logic     id_uses_rt_i,
    output logic     stall_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = (ex_rt_i == id_rs_i);
    assign rt_hit  = id_uses_rt_i & (ex_rt_i == id_rt_i);
    assign stall_o = ex_mem_rd_i & (ex_rt_i != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_uses_rt,
    input  logic [1:0]        id_alu_op,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic              id_reg_w,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic              hold,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_wn,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_w,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_mem_to_reg,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    reg_idx_t                  rs_d, rs_q;
    reg_idx_t                  rt_d, rt_q;
    reg_idx_t                  wn_d, wn_q;
    logic signed [DATA_W-1:0]  rs_val_d, rs_val_q;
    logic signed [DATA_W-1:0]  rt_val_d, rt_val_q;
    logic signed [DATA_W-1:0]  imm_d, imm_q;
    ex_ctrl_t                  ctrl_d, ctrl_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;

    logic stall;
    logic bubble;
    logic clear;
    logic load;

    load_use_detect u_load_use_detect (
        .ex_mem_rd_i  (ctrl_q.mem_rd),
        .ex_rt_i      (rt_q),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .stall_o      (stall)
    );

    // flush outranks hold, hold outranks the bubble, the bubble outranks a normal load
    assign bubble = ~flush & ~hold & stall;
    assign clear  = flush | bubble;
    assign load   = ~flush & ~hold & ~stall;

    always_comb begin
        rs_d     = rs_q;
        rt_d     = rt_q;
        wn_d     = wn_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        cnt_d    = bubble ? sat_inc(cnt_q) : cnt_q;
        if (clear) begin
            rs_d     = '0;
            rt_d     = '0;
            wn_d     = '0;
            rs_val_d = '0;
            rt_val_d = '0;
            imm_d    = '0;
            ctrl_d   = CTRL_NOP;
        end else if (load) begin
            rs_d     = id_rs;
            rt_d     = id_rt;
            wn_d     = id_reg_dst ? id_rd : id_rt;
            rs_val_d = id_rs_val;
            rt_val_d = id_rt_val;
            imm_d    = id_imm;
            ctrl_d   = '{alu_op: id_alu_op, alu_src: id_alu_src, reg_w: id_reg_w,
                         mem_rd: id_mem_rd, mem_wr: id_mem_wr, mem_to_reg: id_mem_to_reg};
        end
    end

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q     <= '0;
            rt_q     <= '0;
            wn_q     <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= CTRL_NOP;
            cnt_q    <= '0;
        end else begin
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            wn_q     <= wn_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_wn         = wn_q;
    assign ex_rs_val     = rs_val_q;
    assign ex_rt_val     = rt_val_q;
    assign ex_imm        = imm_q;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_w      = ctrl_q.reg_w;
    assign ex_mem_rd     = ctrl_q.mem_rd;
    assign ex_mem_wr     = ctrl_q.mem_wr;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign stall_o       = stall;
    assign bubble_cnt    = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, register-file data width in bits.
REQ-002 Parameter CNT_W, default 16, width of the bubble counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_rs, id_rt, id_rd  input  5 each  register specifiers decoded in ID.
REQ-006 id_rs_val, id_rt_val, id_imm  input  DATA_W each  register-file read data and sign-extended immediate.
REQ-007 id_uses_rt  input  1  decoded ID instruction reads rt as a source.
REQ-008 id_alu_op  input  2  ALU op class; 2'b00 means address add.
REQ-009 id_reg_dst, id_alu_src, id_reg_w, id_mem_rd, id_mem_wr, id_mem_to_reg  input  1 each  ID control bits.
REQ-010 flush  input  1  branch/jump squash of the instruction leaving ID.
REQ-011 hold  input  1  downstream memory wait; freezes this stage.
REQ-012 ex_rs, ex_rt  output  5 each  registered specifiers driving forwarding rs/rt.
REQ-013 ex_wn  output  5  destination register, forwarded to EX/MEM.
REQ-014 ex_rs_val, ex_rt_val, ex_imm  output  DATA_W each  registered operands.
REQ-015 ex_alu_op  output  2  registered ALU op class, drives forwarding alu_op.
REQ-016 ex_alu_src, ex_reg_w, ex_mem_rd, ex_mem_wr, ex_mem_to_reg  output  1 each  registered control bits.
REQ-017 stall_o  output  1  load-use stall request to PC and IF/ID.
REQ-018 bubble_cnt  output  CNT_W  count of bubbles inserted since reset.

Function
REQ-019 All ex_* fields and bubble_cnt SHALL be registered, updated only on rising clk.
REQ-020 Per-edge update priority SHALL be: rst, then flush, then hold, then load-use bubble, then normal load.
REQ-021 Normal load SHALL copy every id_* field into the matching ex_* register with one-cycle latency.
REQ-022 ex_wn SHALL be registered as id_rd when id_reg_dst=1, else id_rt.
REQ-023 stall_o SHALL be combinational: ex_mem_rd & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-024 A load-use bubble (stall_o=1, no flush, no hold) SHALL zero all ex_* registers, so reg_w, mem_rd, mem_wr=0 and alu_op=00.
REQ-025 A bubble edge SHALL increment bubble_cnt by 1, saturating at all-ones; flush edges SHALL NOT count.
REQ-026 flush SHALL zero all ex_* registers regardless of hold or stall_o.
REQ-027 hold without flush SHALL keep every ex_* register and bubble_cnt unchanged.
REQ-028 stall_o SHALL NOT be masked by hold; upstream stays frozen through both conditions.
REQ-029 Bubbles SHALL continue on every edge while stall_o persists and only the counter advances; with ex_* zeroed, stall_o self-clears after one bubble.

Reset
REQ-030 On rst=1 at a rising edge, all ex_* outputs and bubble_cnt SHALL be 0, and stall_o therefore 0.
REQ-031 rst asserted mid-stall or mid-hold SHALL override all other inputs on that edge.

Structure
REQ-032 Shared package SHALL hold the ALU op class constants (ALU_ADD=2'b00 etc.) and the register-number width (5).
REQ-033 A single sub-module load_use_detect SHALL compute stall_o; the pipeline register and counter SHALL be inline.

Verification
REQ-034 lw $8 in EX (ex_mem_rd=1, ex_rt=8), ID add with id_rs=8 -> stall_o=1; next edge ex_reg_w=0, ex_alu_op=00, bubble_cnt=1; stall_o=0 afterwards.
REQ-035 ex_mem_rd=1, ex_rt=0, id_rs=0 -> stall_o=0, no bubble, bubble_cnt unchanged.
REQ-036 ex_mem_rd=1, ex_rt=9, id_rt=9, id_uses_rt=0 -> stall_o=0; with id_uses_rt=1 -> stall_o=1.
REQ-037 hold=1 for 3 cycles with a load-use condition present -> ex_* frozen, bubble_cnt unchanged, stall_o=1 throughout; bubble occurs on the first edge after hold drops.
REQ-038 flush=1 and hold=1 on the same edge -> all ex_* zero, bubble_cnt unchanged.
REQ-039 Preload bubble_cnt to 16'hFFFF via repeated bubbles, then one more bubble -> count stays 16'hFFFF; rst -> 0.
